mem_port_arbiter: RTL and testbench

Arbitrates the single-port `DataMemory` between the instruction-fetch requester and the load/store data requester, so the datapath can run from one unified memory. Grants at most one access per cycle, drives the memory's address, write-data and enables, and steers the registered read data back to the requester that issued it. For fetches it also extracts the addressed 32-bit instruction word. Sits between `PCreg`/fetch logic, the datapath load/store path and `DataMemory`.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch requester, the load/store requester, the
// arbiter and the single-port DataMemory. The arbiter uses the slave view;
// requesters and the memory model use the master view.
interface mem_port_arbiter_if;
    // Instruction-fetch requester
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    // Load/store data requester
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        d_err;

    // DataMemory port
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_read_data;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_address, mem_write_data, mem_read, mem_write,
        input  mem_read_data
    );

    // Requester / memory side
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_address, mem_write_data, mem_read, mem_write,
        output mem_read_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port DataMemory between instruction
// fetch and load/store traffic. At most one access is granted per cycle;
// data normally has priority. Read data (1-cycle memory latency) is steered
// back to whichever requester owned the read, with fetches narrowed to the
// addressed 32-bit instruction word. Misaligned data accesses are accepted
// but never reach memory; they return an error instead.
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to enable the fetch
// starvation guard. After MAX_WAIT consecutive lost fetch cycles, fetch wins
// the next conflict. Without it, data has strict priority.
module mem_port_arbiter #(
    parameter int MAX_WAIT = 4   // 1..15
) (
    input  logic                   clk,
    input  logic                   rst,   // asynchronous, active-low
    mem_port_arbiter_if.slave      bus
);

    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_DATA,
        OWN_DERR_LD,
        OWN_DERR_ST
    } owner_e;

    owner_e owner_p1;
    logic   if_hi_p1;

    logic   if_gnt_c;
    logic   d_gnt_c;
    logic   d_misal;
    logic   force_fetch;

    assign d_misal = |bus.d_addr[2:0];

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] starve_cnt;

    // Count consecutive cycles a pending fetch loses; cleared on a fetch grant or idle fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else if (!bus.if_req || if_gnt_c) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign force_fetch = (starve_cnt == WAIT_LIM);
`else
    assign force_fetch = 1'b0;
`endif

    // Grant selection: data first unless the guard says fetch has waited long enough
    always_comb begin
        if_gnt_c = 1'b0;
        d_gnt_c  = 1'b0;
        if (rst) begin
            if (bus.d_req && !(bus.if_req && force_fetch)) begin
                d_gnt_c = 1'b1;
            end else if (bus.if_req) begin
                if_gnt_c = 1'b1;
            end
        end
    end

    assign bus.if_gnt = if_gnt_c;
    assign bus.d_gnt  = d_gnt_c;

    // Memory port drive: only real (aligned) accesses touch the memory; idle bus is all zero
    always_comb begin
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = 64'd0;
        bus.mem_write_data = 64'd0;
        if (if_gnt_c) begin
            bus.mem_read    = 1'b1;
            bus.mem_address = bus.if_addr;
        end else if (d_gnt_c && !d_misal) begin
            bus.mem_address = bus.d_addr;
            if (bus.d_we) begin
                bus.mem_write      = 1'b1;
                bus.mem_write_data = bus.d_wdata;
            end else begin
                bus.mem_read = 1'b1;
            end
        end
    end

    // Response owner for the next cycle, rebuilt every cycle from this cycle's grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_p1 <= OWN_NONE;
        end else if (if_gnt_c) begin
            owner_p1 <= OWN_FETCH;
        end else if (d_gnt_c && d_misal) begin
            owner_p1 <= bus.d_we ? OWN_DERR_ST : OWN_DERR_LD;
        end else if (d_gnt_c && !bus.d_we) begin
            owner_p1 <= OWN_DATA;
        end else begin
            owner_p1 <= OWN_NONE;
        end
    end

    // Remember which half of the 64-bit word holds the fetched instruction
    always_ff @(posedge clk) begin
        if (if_gnt_c) begin
            if_hi_p1 <= bus.if_addr[2];
        end
    end

    // Response steering: outputs are zero unless the registered owner selects them
    always_comb begin
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = 32'd0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = 64'd0;
        bus.d_err     = 1'b0;
        case (owner_p1)
            OWN_FETCH: begin
                bus.if_rvalid = 1'b1;
                bus.if_rdata  = if_hi_p1 ? bus.mem_read_data[63:32]
                                         : bus.mem_read_data[31:0];
            end
            OWN_DATA: begin
                bus.d_rvalid = 1'b1;
                bus.d_rdata  = bus.mem_read_data;
            end
            OWN_DERR_LD: begin
                bus.d_rvalid = 1'b1;
                bus.d_err    = 1'b1;
            end
            OWN_DERR_ST: begin
                bus.d_err = 1'b1;
            end
            default: begin
                bus.if_rvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small DataMemory model.
module tb_mem_port_arbiter;

    localparam int OBS_W = 231;

    logic clk;
    logic rst;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMemory model: synchronous write, registered read
    logic [63:0] mem [0:63];
    logic [63:0] mem_rd_q;
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_address[8:3]] <= bus.mem_write_data;
        if (bus.mem_read)  mem_rd_q <= mem[bus.mem_address[8:3]];
    end
    assign bus.mem_read_data = mem_rd_q;

    typedef struct {
        logic              if_req;
        logic [63:0]       if_addr;
        logic              d_req;
        logic              d_we;
        logic [63:0]       d_addr;
        logic [63:0]       d_wdata;
        logic [OBS_W-1:0]  exp;
    } vec_t;

    int n_vec;
    int n_bad;

    function automatic logic [OBS_W-1:0] pack_obs(
        input logic gi, input logic gd, input logic mr, input logic mw,
        input logic [63:0] ma, input logic [63:0] mwd,
        input logic irv, input logic [31:0] ird,
        input logic drv, input logic der, input logic [63:0] drd);
        return {gi, gd, mr, mw, ma, mwd, irv, ird, drv, der, drd};
    endfunction

    function automatic vec_t mk(
        input logic ir, input logic [63:0] ia, input logic dr, input logic dw,
        input logic [63:0] da, input logic [63:0] dwd,
        input logic gi, input logic gd, input logic mr, input logic mw,
        input logic [63:0] ma, input logic [63:0] mwd,
        input logic irv, input logic [31:0] ird,
        input logic drv, input logic der, input logic [63:0] drd);
        vec_t v;
        v.if_req  = ir;
        v.if_addr = ia;
        v.d_req   = dr;
        v.d_we    = dw;
        v.d_addr  = da;
        v.d_wdata = dwd;
        v.exp     = pack_obs(gi, gd, mr, mw, ma, mwd, irv, ird, drv, der, drd);
        return v;
    endfunction

    function automatic logic [OBS_W-1:0] cur_obs();
        return pack_obs(bus.if_gnt, bus.d_gnt, bus.mem_read, bus.mem_write,
                        bus.mem_address, bus.mem_write_data,
                        bus.if_rvalid, bus.if_rdata,
                        bus.d_rvalid, bus.d_err, bus.d_rdata);
    endfunction

    task automatic check(input string name, input logic [OBS_W-1:0] act,
                         input logic [OBS_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [63:0] ia, input logic dr,
                         input logic dw, input logic [63:0] da, input logic [63:0] dwd);
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
    endtask

    vec_t vecs [12];

    initial begin
        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < 64; i++) mem[i] = 64'd0;
        mem[0] = 64'hAAAA_BBBB_CCCC_DDDD;
        mem[1] = 64'h0123_4567_89AB_CDEF;
        mem_rd_q = 64'd0;

        // Each record: inputs, then grants/memory drive for this cycle and the
        // response produced by the previous record's grant.
        vecs[0]  = mk(0, 64'h0,  0, 0, 64'h0,  64'h0,      0, 0, 0, 0, 64'h0,  64'h0,      0, 32'h0,        0, 0, 64'h0);
        vecs[1]  = mk(1, 64'h4,  0, 0, 64'h0,  64'h0,      1, 0, 1, 0, 64'h4,  64'h0,      0, 32'h0,        0, 0, 64'h0);
        vecs[2]  = mk(1, 64'h0,  0, 0, 64'h0,  64'h0,      1, 0, 1, 0, 64'h0,  64'h0,      1, 32'hAAAABBBB, 0, 0, 64'h0);
        vecs[3]  = mk(0, 64'h0,  1, 1, 64'h10, 64'h1234,   0, 1, 0, 1, 64'h10, 64'h1234,   1, 32'hCCCCDDDD, 0, 0, 64'h0);
        vecs[4]  = mk(0, 64'h0,  1, 0, 64'h10, 64'h0,      0, 1, 1, 0, 64'h10, 64'h0,      0, 32'h0,        0, 0, 64'h0);
        vecs[5]  = mk(0, 64'h0,  1, 0, 64'h13, 64'h0,      0, 1, 0, 0, 64'h0,  64'h0,      0, 32'h0,        1, 0, 64'h1234);
        vecs[6]  = mk(0, 64'h0,  0, 0, 64'h0,  64'h0,      0, 0, 0, 0, 64'h0,  64'h0,      0, 32'h0,        1, 1, 64'h0);
        vecs[7]  = mk(0, 64'h0,  1, 1, 64'h21, 64'h5555,   0, 1, 0, 0, 64'h0,  64'h0,      0, 32'h0,        0, 0, 64'h0);
        vecs[8]  = mk(0, 64'h0,  1, 0, 64'h8,  64'h0,      0, 1, 1, 0, 64'h8,  64'h0,      0, 32'h0,        0, 1, 64'h0);
        vecs[9]  = mk(1, 64'hC,  0, 0, 64'h0,  64'h0,      1, 0, 1, 0, 64'hC,  64'h0,      0, 32'h0,        1, 0, 64'h0123_4567_89AB_CDEF);
        vecs[10] = mk(0, 64'h0,  0, 0, 64'h0,  64'h0,      0, 0, 0, 0, 64'h0,  64'h0,      1, 32'h01234567, 0, 0, 64'h0);
        vecs[11] = mk(0, 64'h0,  0, 0, 64'h0,  64'h0,      0, 0, 0, 0, 64'h0,  64'h0,      0, 32'h0,        0, 0, 64'h0);

        // Reset held with both requests active: nothing may be granted or returned
        rst = 1'b0;
        drive(1, 64'h0, 1, 0, 64'h8, 64'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2;
            check($sformatf("reset_quiet_%0d", c),
                  {{(OBS_W-7){1'b0}}, bus.if_gnt, bus.d_gnt, bus.mem_read, bus.mem_write,
                   bus.if_rvalid, bus.d_rvalid, bus.d_err},
                  {OBS_W{1'b0}});
        end
        #1;
        rst = 1'b1;
        drive(0, 64'h0, 0, 0, 64'h0, 64'h0);
        @(posedge clk);

        // Table-driven single-cycle vectors
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].d_req, vecs[i].d_we,
                  vecs[i].d_addr, vecs[i].d_wdata);
            #1;
            check($sformatf("vec_%0d", i), cur_obs(), vecs[i].exp);
        end

        // Sustained conflict: data wins, unless the guard hands every fifth slot to fetch
        for (int c = 0; c < 10; c++) begin
            logic [1:0] exp_g;
            @(posedge clk);
            #1;
            drive(1, 64'h0, 1, 0, 64'h8, 64'h0);
            #1;
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_g = ((c % 5) == 4) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            check($sformatf("conflict_%0d", c),
                  {{(OBS_W-2){1'b0}}, bus.if_gnt, bus.d_gnt},
                  {{(OBS_W-2){1'b0}}, exp_g});
        end
        @(posedge clk);
        #1;
        drive(0, 64'h0, 0, 0, 64'h0, 64'h0);

        // Reset between a fetch grant and its response edge drops the response
        @(posedge clk);
        #1;
        drive(1, 64'h4, 0, 0, 64'h0, 64'h0);
        #1;
        check("midflight_grant", {{(OBS_W-1){1'b0}}, bus.if_gnt}, {{(OBS_W-1){1'b0}}, 1'b1});
        #5;
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("midflight_no_rvalid",
              {{(OBS_W-2){1'b0}}, bus.if_rvalid, bus.d_rvalid}, {OBS_W{1'b0}});
        drive(0, 64'h0, 0, 0, 64'h0, 64'h0);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("after_reset_idle",
              {{(OBS_W-2){1'b0}}, bus.if_rvalid, bus.d_rvalid}, {OBS_W{1'b0}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
